if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction prefetch unit that sits directly upstream of the IF stage of the 5-stage pipeline.
//  - Fetches sequential words from a variable-latency instruction memory.
//  - Buffers them in a small FIFO and presents {inst, pc, pc4} to IF.
//  - Honours the pipeline stall and flushes on branch/jump redirect from ID.
// PARAMETERS
//  DEPTH     4             FIFO entries; power of 2, >=2
//  RESET_PC  32'h00000000  first fetch address after reset (byte address)
// PORTS
//  Clock        in   1   single clock, rising edge
//  Resetn       in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request; held with imem_addr stable until imem_ack
//  imem_addr    out  32  byte address of requested word, word-aligned
//  imem_ack     in   1   rdata valid; may assert in the same cycle as imem_req
//  imem_rdata   in   32  instruction word
//  redirect     in   1   one-cycle pulse: branch/jump taken (pcsource!=0)
//  redirect_pc  in   32  new fetch target (bpc/jpc)
//  inst_ready   in   1   IF can accept (= ~stall)
//  inst_valid   out  1   queue head valid
//  inst         out  32  head instruction
//  inst_pc      out  32  head address
//  inst_pc4     out  32  inst_pc + 4
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC; count=0; imem_req=0; inst_valid=0; drop=0.
//    inst, inst_pc, inst_pc4 = 0.
//  - Fetch FSM states:
//    - IDLE: imem_req low.
//    - REQ: imem_req high, imem_addr=fetch_pc.
//    - IDLE->REQ when occupancy after this cycle's push/pop < DEPTH and no redirect this cycle.
//    - REQ->IDLE or REQ->REQ on imem_ack.
//  - On an accepted ack (drop=0): push {rdata, fetch_pc}; fetch_pc += 4 (mod 2^32).
//  - Only one outstanding request.
//  - Pop: inst_valid && inst_ready. Head advances next cycle.
//  - Occupancy: push+pop in the same cycle leaves count unchanged. No push is ever issued into a full queue.
//  - Redirect:
//    - FIFO cleared; fetch_pc=redirect_pc; inst_valid=0 next cycle.
//    - Redirect wins over a same-cycle pop or push.
//    - If a request is pending without a same-cycle ack, imem_req/imem_addr stay held.
//      drop=1; that ack is discarded; drop clears on it.
//    - The next request (to redirect_pc) starts the cycle after the discarded ack.
//    - A redirect in the same cycle as an ack discards the ack immediately.
//  - Redirect while drop=1: fetch_pc is overwritten; drop stays set.
//  - Asynchronous reset mid-request: everything returns to reset values.
//    Acks arriving while imem_req=0 are ignored.
//  - Latency:
//    - Zero-wait memory: first inst_valid 2 cycles after Resetn deasserts.
//    - Steady state: 1 instr/cycle only with same-cycle ack; otherwise 1 per (wait+1) cycles.
// CONFIGURATION
//  IFQ_BYPASS_EN
//   - Defined: when FIFO is empty, drop=0, no redirect, and an ack arrives:
//     - imem_rdata/imem_addr drive inst/inst_pc combinationally; inst_valid=1 in the ack cycle.
//     - If inst_ready=1 the word is consumed and not written; otherwise it is pushed.
//   - Undefined: acked words always enter the FIFO; inst_valid rises the following cycle.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - INST_W=32, ADDR_W=32, RESET_PC default.
//    - NOP encoding 32'h00000000 (driven on inst when !inst_valid).
//  - Sub-module ifq_fifo:
//    - Synchronous FIFO: DEPTH, width 64 {pc, inst}; push/pop/clear; count/full/empty.
//    - Asynchronous active-low reset.
//  - Top: fetch FSM, drop flag, bypass mux.
// TESTING
//  1. Reset, zero-wait memory, inst_ready=1 -> inst_pc 0,4,8,... one per cycle; inst = mem[pc>>2].
//  2. inst_ready=0 for 10 cycles -> exactly DEPTH=4 words buffered, imem_req low.
//     Release -> pcs 0,4,8,12,16 in order, no gap or duplicate.
//  3. 3-wait memory, redirect to 32'h40 while request for 32'h08 is pending
//     -> 32'h08 word discarded; next imem_addr=32'h40; first inst_pc=32'h40.
//  4. redirect in the same cycle as pop and ack -> queue empty next cycle; only redirect_pc stream appears.
//  5. Resetn low mid-request with 2 entries queued -> inst_valid=0, imem_req=0 immediately.
//     Restart at RESET_PC.
//  6. IFQ_BYPASS_EN, empty queue, zero-wait memory -> inst_valid in the same cycle as ack.
//     Undefined: one cycle later.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Package for the instruction prefetch queue.
// Contents: data/address widths, default reset PC, the NOP encoding, the fetch
// FSM state type and the packed FIFO entry {pc, inst}.
// Optional feature macro used by the top: IFQ_BYPASS_EN.
package if_prefetch_queue_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP              = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, the instruction memory and IF/ID.
// Ports (master = prefetch queue view):
//   out: imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4
//   in : imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
// Handshakes:
//   imem: imem_req/imem_addr are held stable until imem_ack; a cycle with
//         imem_req && imem_ack completes the transfer (ack may be same cycle).
//         imem_ack while imem_req is low carries no meaning.
//   IF  : inst_valid && inst_ready transfers the head word; inst/inst_pc/
//         inst_pc4 are meaningful only while inst_valid is high.
interface if_prefetch_queue_if;
    import if_prefetch_queue_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_ready;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] inst_pc4;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// Synchronous FIFO holding prefetched {pc, inst} entries.
// Ports: clk, rst_n (async active-low), push/pop/clear, wdata -> rdata (head),
//        count (occupancy), full, empty.
// clear has priority over push/pop. The caller never pushes when full nor
// pops when empty.
module if_prefetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding the IF stage.
// Fetches sequential words from a variable-latency instruction memory (one
// request outstanding), buffers them in a DEPTH-entry FIFO and presents
// {inst, inst_pc, inst_pc4} to IF. A redirect from ID flushes the queue and
// restarts fetching at redirect_pc; a request already in flight is completed
// and its data discarded (drop flag).
// Ports: Clock, Resetn (async active-low), bus (if_prefetch_queue_if.master),
//        dbg_state (fetch FSM state).
// Macro: IFQ_BYPASS_EN - when defined, an ack arriving with the queue empty is
//        presented to IF in the same cycle (consumed directly if inst_ready).
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    if_prefetch_queue_if.master  bus,
    output fetch_state_t         dbg_state
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t      state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic              drop;
    logic              drop_next;

    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic [$bits(ifq_entry_t)-1:0] fifo_rdata;
    ifq_entry_t        head;
    ifq_entry_t        wr_entry;

    logic ack_valid, accept, byp, valid_int, deq, q_push, q_pop, room;

    always_comb begin
        ack_valid = req_q & bus.imem_ack;
        // Redirect kills any same-cycle ack; drop kills the ack of a request
        // that was issued before an earlier redirect.
        accept    = ack_valid & ~drop & ~bus.redirect;
`ifdef IFQ_BYPASS_EN
        byp       = accept & fifo_empty;
`else
        byp       = 1'b0;
`endif
        valid_int = ~fifo_empty | byp;
        deq       = valid_int & bus.inst_ready & ~bus.redirect;
        q_pop     = deq & ~fifo_empty;
        q_push    = accept & ~fifo_full & ~(byp & bus.inst_ready);
        count_next = bus.redirect ? '0
                                  : fifo_count + CW'(q_push) - CW'(q_pop);
        room      = (count_next < DEPTH_C);
        if (bus.redirect)  fetch_pc_next = bus.redirect_pc;
        else if (accept)   fetch_pc_next = fetch_pc + 32'd4;
        else               fetch_pc_next = fetch_pc;
        // drop lives only while the orphaned request is still waiting.
        drop_next = req_q & ~bus.imem_ack & (drop | bus.redirect);
        wr_entry  = '{pc: fetch_pc, inst: bus.imem_rdata};
        head      = ifq_entry_t'(fifo_rdata);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= ST_IDLE;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_next;
            drop     <= drop_next;
            case (state)
                ST_IDLE: begin
                    if (room && !bus.redirect) begin
                        state  <= ST_REQ;
                        req_q  <= 1'b1;
                        addr_q <= fetch_pc_next;
                    end
                end
                ST_REQ: begin
                    // Address is held until the ack; then either chain the
                    // next request or rest while the queue is full.
                    if (bus.imem_ack) begin
                        if (room) begin
                            addr_q <= fetch_pc_next;
                        end else begin
                            state <= ST_IDLE;
                            req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    if_prefetch_queue_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ifq_entry_t))
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Resetn),
        .push  (q_push),
        .pop   (q_pop),
        .clear (bus.redirect),
        .wdata (wr_entry),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        bus.inst     = NOP;
        bus.inst_pc  = '0;
        bus.inst_pc4 = '0;
        if (byp) begin
            bus.inst     = bus.imem_rdata;
            bus.inst_pc  = addr_q;
            bus.inst_pc4 = addr_q + 32'd4;
        end else if (!fifo_empty) begin
            bus.inst     = head.inst;
            bus.inst_pc  = head.pc;
            bus.inst_pc4 = head.pc + 32'd4;
        end
    end

    assign bus.inst_valid = valid_int;
    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: memory responder with programmable wait states,
// directed scenarios, scoreboard queue of expected pcs popped by a monitor.
module tb_if_prefetch_queue;
    import if_prefetch_queue_pkg::*;

`ifdef IFQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic         Clock;
    logic         Resetn;
    fetch_state_t dbg_state;
    if_prefetch_queue_if bus();

    int checks   = 0;
    int failures = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    int acks_seen = 0;
    logic stray_ack = 1'b0;
    logic [31:0] exp_q[$];

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus.imem_ack   = (bus.imem_req && (wait_cnt == mem_wait)) || stray_ack;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    always @(posedge Clock) begin
        if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
        if (bus.imem_req && bus.imem_ack)  acks_seen <= acks_seen + 1;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (Resetn && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%h required=none", bus.inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_eq("pop_pc", bus.inst_pc, e);
                check_eq("pop_inst", bus.inst, mem_word(e));
                check_eq("pop_pc4", bus.inst_pc4, e + 32'd4);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic reset_dut(input int wait_states);
        Resetn          = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b0;
        stray_ack       = 1'b0;
        mem_wait        = wait_states;
        repeat (2) @(negedge Clock);
        check_eq("rst_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_inst", bus.inst, 32'd0);
        check_eq("rst_pc", bus.inst_pc, 32'd0);
        check_eq("rst_pc4", bus.inst_pc4, 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge Clock); #1;
        Resetn = 1'b1;
    endtask

    // Hold inst_ready until n pops are committed; strict demands no gaps.
    task automatic consume(input int n, input bit strict);
        int got = 0;
        int cyc = 0;
        int first = 0;
        bus.inst_ready = 1'b1;
        while (got < n && cyc < 200) begin
            @(negedge Clock);
            if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
                if (got == 0) first = cyc;
                got++;
            end
            cyc++;
        end
        @(posedge Clock); #1;
        bus.inst_ready = 1'b0;
        check_eq("consume_count", 32'(got), 32'(n));
        if (strict) check_eq("consume_gap", 32'(cyc - 1 - first), 32'(n - 1));
    endtask

    task automatic wait_req_addr(input logic [31:0] a);
        int cyc = 0;
        do begin
            @(negedge Clock);
            cyc++;
        end while (!(bus.imem_req && bus.imem_addr == a) && cyc < 100);
        check_eq("wait_req_addr", bus.imem_addr, a);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int a0;
        int got;
        int cyc;

        // 1 + 6: latency from reset, then 1 instr/cycle with zero-wait memory
        reset_dut(0);
        @(negedge Clock);
        check_eq("t1_req_before_e1", 32'(bus.imem_req), 32'd0);
        check_eq("t1_valid_before_e1", 32'(bus.inst_valid), 32'd0);
        @(negedge Clock);
        check_eq("t1_req_after_e1", 32'(bus.imem_req), 32'd1);
        check_eq("t1_valid_ack_cycle", 32'(bus.inst_valid), 32'(BYP));
        @(negedge Clock);
        check_eq("t1_valid_after_e2", 32'(bus.inst_valid), 32'd1);
        check_eq("t1_head_pc", bus.inst_pc, 32'h0);
        @(posedge Clock); #1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        consume(8, 1'b1);

        // 2: stall fills exactly DEPTH, stray ack ignored, then in-order drain
        reset_dut(0);
        a0 = acks_seen;
        repeat (10) @(negedge Clock);
        check_eq("t2_req_low_full", 32'(bus.imem_req), 32'd0);
        check_eq("t2_acks", 32'(acks_seen - a0), 32'd4);
        check_eq("t2_head_pc", bus.inst_pc, 32'h0);
        @(posedge Clock); #1;
        stray_ack = 1'b1;
        @(posedge Clock); #1;
        stray_ack = 1'b0;
        check_eq("t2_stray_ignored", 32'(acks_seen - a0), 32'd4);
        exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
        exp_q.push_back(32'h0C); exp_q.push_back(32'h10);
        consume(5, 1'b1);

        // 3: redirect while the 0x08 request waits on a 3-wait memory
        reset_dut(3);
        wait_req_addr(32'h08);
        @(posedge Clock); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        @(posedge Clock); #1;
        bus.redirect    = 1'b0;
        cyc = 0;
        do begin
            @(negedge Clock);
            cyc++;
        end while (!(bus.imem_req && bus.imem_ack) && cyc < 20);
        check_eq("t3_discard_addr", bus.imem_addr, 32'h08);
        @(negedge Clock);
        check_eq("t3_next_req", 32'(bus.imem_req), 32'd1);
        check_eq("t3_next_addr", bus.imem_addr, 32'h40);
        check_eq("t3_flushed", 32'(bus.inst_valid), 32'd0);
        @(posedge Clock); #1;
        exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
        consume(3, 1'b0);

        // 4: redirect coinciding with pop and ack
        reset_dut(0);
        exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
        exp_q.push_back(32'h80); exp_q.push_back(32'h84); exp_q.push_back(32'h88);
        bus.inst_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 50) begin
            @(negedge Clock);
            if (bus.inst_valid && bus.inst_ready) got++;
            cyc++;
        end
        @(posedge Clock); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        @(negedge Clock);
        check_eq("t4_coincide", {29'd0, bus.inst_valid, bus.imem_req, bus.imem_ack}, 32'd7);
        check_eq("t4_head_before", bus.inst_pc, 32'h0C);
        @(posedge Clock); #1;
        bus.redirect = 1'b0;
        @(negedge Clock);
        check_eq("t4_valid_after", 32'(bus.inst_valid), 32'(BYP));
        @(posedge Clock); #1;
        consume(3 - BYP, 1'b0);

        // 5: asynchronous reset mid-request with two words queued
        reset_dut(2);
        wait_req_addr(32'h08);
        #1 Resetn = 1'b0;
        #1;
        check_eq("t5_valid_async", 32'(bus.inst_valid), 32'd0);
        check_eq("t5_req_async", 32'(bus.imem_req), 32'd0);
        check_eq("t5_state_async", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge Clock); #1;
        Resetn = 1'b1;
        wait_req_addr(32'h00);
        @(posedge Clock); #1;
        exp_q.push_back(32'h00); exp_q.push_back(32'h04);
        consume(2, 1'b0);

        repeat (3) @(negedge Clock);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
